// File: rtl/ddr3_port_arbiter.sv
// DDR3 front-end arbiter: one priority burst-read port plus NUM_CLIENTS round-robin
// single-beat cache ports, issuing one command at a time to the DDR3 reader/writer.
module ddr3_port_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 27,
    parameter int BE_W        = 8,
    parameter int MAX_BURST   = 512,
    parameter int ADDR_STEP   = 8,
    parameter int WRAP_BASE   = 0,
    parameter int WRAP_SIZE   = 614400,
    localparam int LEN_W      = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS-1:0]        client_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata,
    input  logic [NUM_CLIENTS*BE_W-1:0]   client_be,
    output logic [NUM_CLIENTS-1:0]        client_ack,
    output logic [DATA_W-1:0]             client_rdata,
    input  logic                          burst_req,
    input  logic [ADDR_W-1:0]             burst_addr,
    input  logic [LEN_W-1:0]              burst_len,
    output logic                          burst_rvalid,
    output logic [DATA_W-1:0]             burst_rdata,
    output logic                          burst_done,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [BE_W-1:0]               mem_be,
    output logic [1:0]                    mem_en,
    output logic                          mem_new_cmd,
    input  logic                          mem_cmd_ack,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int CW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [ADDR_W-1:0] WRAP_END = ADDR_W'(WRAP_BASE + WRAP_SIZE);

    typedef enum logic [2:0] {IDLE, B_ISSUE, B_DRAIN, C_ISSUE, C_WAIT, C_DONE} state_t;

    state_t                  state, next_state;
    logic [CW-1:0]           rr_ptr, gnt, gnt_q, idx;
    logic                    any_req, owe_client, we_q, take_burst;
    logic [LEN_W-1:0]        blen, issue_cnt, recv_cnt;
    logic                    ack_hit, rv_burst, last_ack, last_rv, zero_len;
    logic [ADDR_W-1:0]       addr_inc;
    logic                    mem_new_cmd_d, burst_rvalid_d, burst_done_d;
    logic [1:0]              mem_en_d;
    logic [NUM_CLIENTS-1:0]  client_ack_d;

    // Round-robin search from rr_ptr; iterating downward lets the nearest requester win.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            idx = CW'((int'(rr_ptr) + i) % NUM_CLIENTS);
            if (client_req[idx]) gnt = idx;
        end
    end

    assign any_req    = |client_req;
    assign ack_hit    = mem_new_cmd & mem_cmd_ack;
    assign zero_len   = (blen == '0);
    assign rv_burst   = mem_rvalid & ~zero_len & (state == B_ISSUE || state == B_DRAIN);
    assign last_ack   = ack_hit & (state == B_ISSUE) & (issue_cnt + LEN_W'(1) == blen);
    assign last_rv    = rv_burst & (recv_cnt + LEN_W'(1) == blen);
    // Owed client slot only blocks the burst while some client is actually waiting.
    assign take_burst = burst_req & (~owe_client | ~any_req);
    assign addr_inc   = mem_addr + ADDR_W'(ADDR_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take_burst)            next_state = B_ISSUE;
                     else if (any_req)          next_state = C_ISSUE;
            B_ISSUE: if (zero_len || last_rv)   next_state = IDLE;
                     else if (last_ack)         next_state = B_DRAIN;
            B_DRAIN: if (last_rv)               next_state = IDLE;
            C_ISSUE: if (ack_hit)               next_state = we_q ? C_DONE : C_WAIT;
            C_WAIT:  if (mem_rvalid)            next_state = C_DONE;
            C_DONE:                             next_state = IDLE;
            default:                            next_state = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs.
    always_comb begin
        mem_new_cmd_d  = 1'b0;
        mem_en_d       = 2'b00;
        burst_done_d   = 1'b0;
        client_ack_d   = '0;
        burst_rvalid_d = rv_burst;
        case (state)
            IDLE: begin
                if (take_burst) begin
                    mem_new_cmd_d = (burst_len != '0);
                    mem_en_d      = (burst_len != '0) ? 2'b01 : 2'b00;
                end else if (any_req) begin
                    mem_new_cmd_d = 1'b1;
                    mem_en_d      = client_we[gnt] ? 2'b10 : 2'b01;
                end
            end
            B_ISSUE: begin
                mem_new_cmd_d = mem_new_cmd & ~last_ack;
                mem_en_d      = (mem_new_cmd & ~last_ack) ? 2'b01 : 2'b00;
                burst_done_d  = zero_len | last_rv;
            end
            B_DRAIN: burst_done_d = last_rv;
            C_ISSUE: begin
                mem_new_cmd_d = ~ack_hit;
                mem_en_d      = ack_hit ? 2'b00 : mem_en;
            end
            C_DONE:  client_ack_d[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_new_cmd  <= 1'b0;
            mem_en       <= 2'b00;
            burst_rvalid <= 1'b0;
            burst_done   <= 1'b0;
            client_ack   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            burst_rdata  <= '0;
            client_rdata <= '0;
            blen         <= '0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            rr_ptr       <= '0;
            gnt_q        <= '0;
            we_q         <= 1'b0;
            owe_client   <= 1'b0;
        end else begin
            mem_new_cmd  <= mem_new_cmd_d;
            mem_en       <= mem_en_d;
            burst_rvalid <= burst_rvalid_d;
            burst_done   <= burst_done_d;
            client_ack   <= client_ack_d;
            if (state == IDLE && next_state == B_ISSUE) begin
                mem_addr  <= burst_addr;
                blen      <= burst_len;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (state == IDLE && next_state == C_ISSUE) begin
                mem_addr   <= client_addr[int'(gnt)*ADDR_W +: ADDR_W];
                mem_wdata  <= client_wdata[int'(gnt)*DATA_W +: DATA_W];
                mem_be     <= client_be[int'(gnt)*BE_W +: BE_W];
                we_q       <= client_we[gnt];
                gnt_q      <= gnt;
                rr_ptr     <= (gnt == CW'(NUM_CLIENTS - 1)) ? '0 : gnt + CW'(1);
                owe_client <= 1'b0;
            end
            if (state == B_ISSUE && ack_hit) begin
                mem_addr  <= (addr_inc == WRAP_END) ? ADDR_W'(WRAP_BASE) : addr_inc;
                issue_cnt <= issue_cnt + LEN_W'(1);
            end
            if (rv_burst) begin
                recv_cnt    <= recv_cnt + LEN_W'(1);
                burst_rdata <= mem_rdata;
            end
            if (state == C_WAIT && mem_rvalid) client_rdata <= mem_rdata;
            if (burst_done_d && any_req) owe_client <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: burst, wrap, round robin, starvation guard,
// zero-length burst and mid-burst reset, with a small in-order DDR responder.
module tb_ddr3_port_arbiter;
    localparam int NC = 4;
    localparam int DW = 128;
    localparam int AW = 27;
    localparam int BW = 8;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]    client_req, client_we, client_ack;
    logic [NC*AW-1:0] client_addr;
    logic [NC*DW-1:0] client_wdata;
    logic [NC*BW-1:0] client_be;
    logic [DW-1:0]    client_rdata;
    logic             burst_req, burst_rvalid, burst_done;
    logic [AW-1:0]    burst_addr;
    logic [LW-1:0]    burst_len;
    logic [DW-1:0]    burst_rdata;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata, mem_rdata;
    logic [BW-1:0]    mem_be;
    logic [1:0]       mem_en;
    logic             mem_new_cmd, mem_cmd_ack, mem_rvalid;

    always #5 clk = ~clk;

    ddr3_port_arbiter #(
        .NUM_CLIENTS(NC), .DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .MAX_BURST(512),
        .ADDR_STEP(8), .WRAP_BASE(0), .WRAP_SIZE(32)
    ) dut (
        .clk(clk), .reset(reset),
        .client_req(client_req), .client_we(client_we), .client_addr(client_addr),
        .client_wdata(client_wdata), .client_be(client_be), .client_ack(client_ack),
        .client_rdata(client_rdata),
        .burst_req(burst_req), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_rvalid(burst_rvalid), .burst_rdata(burst_rdata), .burst_done(burst_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_en(mem_en),
        .mem_new_cmd(mem_new_cmd), .mem_cmd_ack(mem_cmd_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc, ndone, done_cyc, done_nb, newcmd_cnt, first_cmd_cyc, first_ack_cyc, npend, seq;
    bit ack_on, rsp_on, drop_burst, drop_clients;
    logic [AW-1:0] q_addr[$];
    logic [1:0]    q_en[$];
    logic [BW-1:0] q_be[$];
    logic [DW-1:0] q_wd[$];
    logic [DW-1:0] q_bv[$];
    logic [DW-1:0] q_crd[$];
    int            q_ack[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q_addr.delete(); q_en.delete(); q_be.delete(); q_wd.delete();
        q_bv.delete(); q_crd.delete(); q_ack.delete();
        cyc = 0; ndone = 0; done_cyc = -1; done_nb = -1; newcmd_cnt = 0;
        first_cmd_cyc = -1; first_ack_cyc = -1; npend = 0; seq = 0;
    endtask

    // One clock: drive responder inputs, log accepted commands, advance, log DUT outputs.
    task automatic tick();
        logic [1:0] k;
        mem_cmd_ack = ack_on;
        mem_rvalid  = 1'b0;
        if (rsp_on && npend > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 128'h1000 + 128'(seq);
            seq++;
            npend--;
        end
        if (mem_new_cmd && ack_on) begin
            q_addr.push_back(mem_addr); q_en.push_back(mem_en);
            q_be.push_back(mem_be);     q_wd.push_back(mem_wdata);
            if (mem_en == 2'b01) npend++;
        end
        @(posedge clk); #1;
        cyc++;
        if (mem_new_cmd) begin
            newcmd_cnt++;
            if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
        end
        if (burst_rvalid) q_bv.push_back(burst_rdata);
        if (burst_done) begin
            ndone++; done_cyc = cyc; done_nb = q_bv.size();
            if (drop_burst) burst_req = 1'b0;
        end
        for (int i = 0; i < NC; i++) begin
            k = 2'(i);
            if (client_ack[k]) begin
                q_ack.push_back(i); q_crd.push_back(client_rdata);
                if (first_ack_cyc < 0) first_ack_cyc = cyc;
                if (drop_clients) client_req[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; burst_req = 1'b0; client_req = '0; ack_on = 1'b0; rsp_on = 1'b0;
        mem_cmd_ack = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; npend = 0;
    endtask

    initial begin
        int n;
        int exp_a[4];
        reset = 1'b1; client_req = '0; client_we = '0; client_addr = '0; client_wdata = '0;
        client_be = '0; burst_req = 1'b0; burst_addr = '0; burst_len = '0;
        mem_cmd_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        ack_on = 1'b0; rsp_on = 1'b0; drop_burst = 1'b0; drop_clients = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_new_cmd", 128'(mem_new_cmd), 128'd0);
        chk("rst_en", 128'(mem_en), 128'd0);
        chk("rst_addr", 128'(mem_addr), 128'd0);
        chk("rst_cack", 128'(client_ack), 128'd0);
        chk("rst_bdone", 128'(burst_done), 128'd0);
        reset = 1'b0;

        // Burst of 4 from address 0, ack every cycle.
        clr(); ack_on = 1; rsp_on = 1; drop_burst = 1;
        burst_addr = 27'd0; burst_len = 10'd4; burst_req = 1'b1;
        n = 0;
        while (ndone == 0 && n < 40) begin tick(); n++; end
        chk("b_done_cnt", 128'(ndone), 128'd1);
        chk("b_done_cyc", 128'(done_cyc), 128'd6);
        chk("b_done_with_4th", 128'(done_nb), 128'd4);
        chk("b_first_cmd", 128'(first_cmd_cyc), 128'd1);
        chk("b_ncmd", 128'(q_addr.size()), 128'd4);
        exp_a = '{0, 8, 16, 24};
        for (int i = 0; i < 4; i++) begin
            chk("b_addr", 128'(q_addr[i]), 128'(exp_a[i]));
            chk("b_en", 128'(q_en[i]), 128'd1);
            chk("b_rdata", q_bv[i], 128'h1000 + 128'(i));
        end
        tick(); tick();
        chk("b_idle_cmd", 128'(mem_new_cmd), 128'd0);
        chk("b_ncmd_after", 128'(q_addr.size()), 128'd4);

        // Wrap at WRAP_BASE+WRAP_SIZE = 32.
        clr(); burst_addr = 27'd16; burst_len = 10'd4; burst_req = 1'b1;
        n = 0;
        while (ndone == 0 && n < 40) begin tick(); n++; end
        chk("w_done_cnt", 128'(ndone), 128'd1);
        chk("w_ncmd", 128'(q_addr.size()), 128'd4);
        exp_a = '{16, 24, 0, 8};
        for (int i = 0; i < 4; i++) chk("w_addr", 128'(q_addr[i]), 128'(exp_a[i]));

        // Round robin: clients 0 and 2 read continuously.
        do_reset(); clr(); ack_on = 1; rsp_on = 1; drop_clients = 0;
        client_addr[0*AW +: AW] = 27'h100;
        client_addr[2*AW +: AW] = 27'h200;
        client_we = 4'b0000; client_req = 4'b0101;
        n = 0;
        while (q_ack.size() < 4 && n < 80) begin tick(); n++; end
        client_req = '0;
        chk("rr_nack", 128'(q_ack.size()), 128'd4);
        chk("rr_first_ack_cyc", 128'(first_ack_cyc), 128'd4);
        exp_a = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant", 128'(q_ack[i]), 128'(exp_a[i]));
            chk("rr_rdata", q_crd[i], 128'h1000 + 128'(i));
            chk("rr_addr", 128'(q_addr[i]), (exp_a[i] == 0) ? 128'h100 : 128'h200);
        end

        // Starvation guard: burst, client 1 write, burst.
        do_reset(); clr(); ack_on = 1; rsp_on = 1; drop_burst = 0; drop_clients = 1;
        client_addr[1*AW +: AW] = 27'h340;
        client_wdata[1*DW +: DW] = 128'hBEEF_0001;
        client_be[1*BW +: BW] = 8'hA5;
        client_we = 4'b0010; client_req = 4'b0010;
        burst_addr = 27'd0; burst_len = 10'd2; burst_req = 1'b1;
        n = 0;
        while (ndone < 2 && n < 80) begin tick(); n++; end
        burst_req = 1'b0;
        chk("s_done_cnt", 128'(ndone), 128'd2);
        chk("s_ncmd", 128'(q_addr.size()), 128'd5);
        chk("s_addr0", 128'(q_addr[0]), 128'd0);
        chk("s_addr1", 128'(q_addr[1]), 128'd8);
        chk("s_addr2", 128'(q_addr[2]), 128'h340);
        chk("s_addr3", 128'(q_addr[3]), 128'd0);
        chk("s_en_burst", 128'(q_en[0]), 128'd1);
        chk("s_en_write", 128'(q_en[2]), 128'd2);
        chk("s_be", 128'(q_be[2]), 128'hA5);
        chk("s_wdata", q_wd[2], 128'hBEEF_0001);
        chk("s_nack", 128'(q_ack.size()), 128'd1);
        chk("s_ack_client", 128'(q_ack[0]), 128'd1);

        // Zero-length burst.
        do_reset(); clr(); ack_on = 1; rsp_on = 1; drop_burst = 1; drop_clients = 0;
        burst_addr = 27'd0; burst_len = 10'd0; burst_req = 1'b1;
        n = 0;
        while (ndone == 0 && n < 10) begin tick(); n++; end
        tick(); tick(); tick();
        chk("z_done_cnt", 128'(ndone), 128'd1);
        chk("z_done_cyc", 128'(done_cyc), 128'd2);
        chk("z_no_cmd", 128'(newcmd_cnt), 128'd0);

        // Reset mid-burst; stray returns afterwards must be dropped.
        do_reset(); clr(); ack_on = 1; rsp_on = 0; drop_burst = 1;
        burst_addr = 27'd0; burst_len = 10'd8; burst_req = 1'b1;
        tick(); tick(); tick();
        chk("r_pre_addr", 128'(mem_addr), 128'd16);
        chk("r_pre_cmd", 128'(mem_new_cmd), 128'd1);
        #2;
        reset = 1'b1; burst_req = 1'b0;
        #1;
        chk("r_cmd", 128'(mem_new_cmd), 128'd0);
        chk("r_en", 128'(mem_en), 128'd0);
        chk("r_addr", 128'(mem_addr), 128'd0);
        chk("r_brv", 128'(burst_rvalid), 128'd0);
        chk("r_bdone", 128'(burst_done), 128'd0);
        chk("r_cack", 128'(client_ack), 128'd0);
        tick();
        reset = 1'b0; rsp_on = 1;
        repeat (6) tick();
        chk("r_stray_rv", 128'(q_bv.size()), 128'd0);
        chk("r_stray_done", 128'(ndone), 128'd0);
        chk("r_idle_cmd", 128'(mem_new_cmd), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
